// File: rtl/wb_stage.sv
// RV32I writeback stage: registers regfile writes, extracts/extends load data, stalls MEM on a pending load.
// Optional retire counter (Instret port) built only when WB_INSTRET_EN is defined.
module wb_stage #(
    parameter int REG_DATA_WIDTH     = 32,
    parameter int REGFILE_ADDR_WIDTH = 5,
    parameter int INSTRET_WIDTH      = 64
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          Mem_valid,
    output logic                          Mem_ready,
    input  logic [REGFILE_ADDR_WIDTH-1:0] Mem_rd_addr,
    input  logic                          Mem_rd_wr_en,
    input  logic                          Mem_is_load,
    input  logic [2:0]                    Mem_funct3,
    input  logic [1:0]                    Mem_byte_off,
    input  logic [REG_DATA_WIDTH-1:0]     Mem_alu_result,
    input  logic                          Flush,
    input  logic                          Dmem_rvalid,
    input  logic [REG_DATA_WIDTH-1:0]     Dmem_rdata,
    output logic [REGFILE_ADDR_WIDTH-1:0] Rd_addr,
    output logic [REG_DATA_WIDTH-1:0]     Rd_wr_data,
    output logic                          Rd_wr_en,
    output logic                          Wb_busy
`ifdef WB_INSTRET_EN
    ,
    output logic [INSTRET_WIDTH-1:0]      Instret
`endif
);

    typedef enum logic {S_IDLE, S_WAIT_LOAD} state_t;

    state_t                          state_q, state_d;
    logic [REGFILE_ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
    logic [REG_DATA_WIDTH-1:0]       rd_data_q, rd_data_d;
    logic                            rd_we_q, rd_we_d;
    logic [REGFILE_ADDR_WIDTH-1:0]   pend_rd_q, pend_rd_d;
    logic                            pend_we_q, pend_we_d;
    logic [2:0]                      pend_f3_q, pend_f3_d;
    logic [1:0]                      pend_off_q, pend_off_d;
    logic                            accept;
    logic                            done;
    logic                            mem_we;

    function automatic logic [REG_DATA_WIDTH-1:0] extract(input logic [2:0] f3,
                                                          input logic [1:0] off,
                                                          input logic [REG_DATA_WIDTH-1:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = w[{off[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  extract = {{(REG_DATA_WIDTH-8){b[7]}}, b};
            3'b100:  extract = {{(REG_DATA_WIDTH-8){1'b0}}, b};
            3'b001:  extract = {{(REG_DATA_WIDTH-16){h[15]}}, h};
            3'b101:  extract = {{(REG_DATA_WIDTH-16){1'b0}}, h};
            3'b010:  extract = w;
            default: extract = '0;
        endcase
    endfunction

    assign Mem_ready = !Reset && (state_q == S_IDLE);
    assign accept    = Mem_valid && Mem_ready && !Flush;
    assign mem_we    = Mem_rd_wr_en && (Mem_rd_addr != '0);

    always_comb begin
        state_d    = state_q;
        rd_addr_d  = rd_addr_q;
        rd_data_d  = rd_data_q;
        rd_we_d    = 1'b0;
        pend_rd_d  = pend_rd_q;
        pend_we_d  = pend_we_q;
        pend_f3_d  = pend_f3_q;
        pend_off_d = pend_off_q;
        done       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (!Mem_is_load) begin
                        done      = 1'b1;
                        rd_addr_d = Mem_rd_addr;
                        rd_data_d = Mem_alu_result;
                        rd_we_d   = mem_we;
                    end else if (Dmem_rvalid) begin
                        done      = 1'b1;
                        rd_addr_d = Mem_rd_addr;
                        rd_data_d = extract(Mem_funct3, Mem_byte_off, Dmem_rdata);
                        rd_we_d   = mem_we;
                    end else begin
                        pend_rd_d  = Mem_rd_addr;
                        pend_we_d  = mem_we;
                        pend_f3_d  = Mem_funct3;
                        pend_off_d = Mem_byte_off;
                        state_d    = S_WAIT_LOAD;
                    end
                end
            end
            S_WAIT_LOAD: begin
                // Flush is ignored here: the waiting instruction has already committed.
                if (Dmem_rvalid) begin
                    done      = 1'b1;
                    rd_addr_d = pend_rd_q;
                    rd_data_d = extract(pend_f3_q, pend_off_q, Dmem_rdata);
                    rd_we_d   = pend_we_q;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            rd_addr_q  <= '0;
            rd_data_q  <= '0;
            rd_we_q    <= 1'b0;
            pend_rd_q  <= '0;
            pend_we_q  <= 1'b0;
            pend_f3_q  <= '0;
            pend_off_q <= '0;
        end else begin
            state_q    <= state_d;
            rd_addr_q  <= rd_addr_d;
            rd_data_q  <= rd_data_d;
            rd_we_q    <= rd_we_d;
            pend_rd_q  <= pend_rd_d;
            pend_we_q  <= pend_we_d;
            pend_f3_q  <= pend_f3_d;
            pend_off_q <= pend_off_d;
        end
    end

    assign Rd_addr    = rd_addr_q;
    assign Rd_wr_data = rd_data_q;
    assign Rd_wr_en   = rd_we_q;
    assign Wb_busy    = (state_q == S_WAIT_LOAD);

`ifdef WB_INSTRET_EN
    logic [INSTRET_WIDTH-1:0] instret_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            instret_q <= '0;
        end else if (done) begin
            instret_q <= instret_q + INSTRET_WIDTH'(1);
        end
    end

    assign Instret = instret_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: expected regfile writes are queued as beats are driven and popped at each edge.
module tb_wb_stage;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Mem_valid;
    logic        Mem_ready;
    logic [4:0]  Mem_rd_addr;
    logic        Mem_rd_wr_en;
    logic        Mem_is_load;
    logic [2:0]  Mem_funct3;
    logic [1:0]  Mem_byte_off;
    logic [31:0] Mem_alu_result;
    logic        Flush;
    logic        Dmem_rvalid;
    logic [31:0] Dmem_rdata;
    logic [4:0]  Rd_addr;
    logic [31:0] Rd_wr_data;
    logic        Rd_wr_en;
    logic        Wb_busy;
`ifdef WB_INSTRET_EN
    logic [63:0] Instret;
`endif

    always #5 Clk = ~Clk;

    wb_stage dut (
        .Clk(Clk), .Reset(Reset), .Mem_valid(Mem_valid), .Mem_ready(Mem_ready),
        .Mem_rd_addr(Mem_rd_addr), .Mem_rd_wr_en(Mem_rd_wr_en), .Mem_is_load(Mem_is_load),
        .Mem_funct3(Mem_funct3), .Mem_byte_off(Mem_byte_off), .Mem_alu_result(Mem_alu_result),
        .Flush(Flush), .Dmem_rvalid(Dmem_rvalid), .Dmem_rdata(Dmem_rdata),
        .Rd_addr(Rd_addr), .Rd_wr_data(Rd_wr_data), .Rd_wr_en(Rd_wr_en), .Wb_busy(Wb_busy)
`ifdef WB_INSTRET_EN
        , .Instret(Instret)
`endif
    );

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
        logic        we;
    } wr_t;

    wr_t         sb[$];
    bit          due = 1'b0;
    int          checks = 0;
    int          errors = 0;
    logic [4:0]  last_a = '0;
    logic [31:0] last_d = '0;
    longint unsigned exp_ir = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_instret(input string tag);
`ifdef WB_INSTRET_EN
        chk(tag, Instret, exp_ir);
`endif
    endtask

    // One clock; checks the write port against the scoreboard (or hold behaviour when nothing completes).
    task automatic tick(input string tag);
        wr_t w;
        @(posedge Clk);
        #1;
        if (Reset) begin
            sb.delete();
            due    = 1'b0;
            last_a = '0;
            last_d = '0;
            exp_ir = 0;
        end
        if (due) begin
            due = 1'b0;
            if (sb.size() == 0) begin
                chk({tag, ".sb_empty"}, 64'd1, 64'd0);
            end else begin
                w = sb.pop_front();
                chk({tag, ".we"}, {63'd0, Rd_wr_en}, {63'd0, w.we});
                chk({tag, ".addr"}, {59'd0, Rd_addr}, {59'd0, w.a});
                chk({tag, ".data"}, {32'd0, Rd_wr_data}, {32'd0, w.d});
                last_a = w.a;
                last_d = w.d;
                exp_ir++;
            end
        end else begin
            chk({tag, ".idle_we"}, {63'd0, Rd_wr_en}, 64'd0);
            chk({tag, ".hold_addr"}, {59'd0, Rd_addr}, {59'd0, last_a});
            chk({tag, ".hold_data"}, {32'd0, Rd_wr_data}, {32'd0, last_d});
        end
    endtask

    task automatic alu(input logic [4:0] rd, input logic [31:0] res, input logic we, input string tag);
        Mem_valid      = 1'b1;
        Mem_is_load    = 1'b0;
        Mem_rd_addr    = rd;
        Mem_rd_wr_en   = we;
        Mem_alu_result = res;
        Flush          = 1'b0;
        chk({tag, ".ready"}, {63'd0, Mem_ready}, 64'd1);
        sb.push_back('{a: rd, d: res, we: (we && (rd != 5'd0))});
        due = 1'b1;
        tick(tag);
        Mem_valid = 1'b0;
    endtask

    task automatic load_now(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off,
                            input logic [31:0] rdata, input logic [31:0] exp, input string tag);
        Mem_valid    = 1'b1;
        Mem_is_load  = 1'b1;
        Mem_rd_addr  = rd;
        Mem_rd_wr_en = 1'b1;
        Mem_funct3   = f3;
        Mem_byte_off = off;
        Dmem_rvalid  = 1'b1;
        Dmem_rdata   = rdata;
        sb.push_back('{a: rd, d: exp, we: (rd != 5'd0)});
        due = 1'b1;
        tick(tag);
        Mem_valid   = 1'b0;
        Mem_is_load = 1'b0;
        Dmem_rvalid = 1'b0;
        chk({tag, ".busy"}, {63'd0, Wb_busy}, 64'd0);
    endtask

    initial begin
        Reset = 1'b1; Mem_valid = 1'b0; Mem_rd_addr = '0; Mem_rd_wr_en = 1'b0;
        Mem_is_load = 1'b0; Mem_funct3 = '0; Mem_byte_off = '0; Mem_alu_result = '0;
        Flush = 1'b0; Dmem_rvalid = 1'b0; Dmem_rdata = '0;

        // Reset state
        tick("rst0");
        tick("rst1");
        chk("rst.ready", {63'd0, Mem_ready}, 64'd0);
        chk("rst.busy", {63'd0, Wb_busy}, 64'd0);
        chk_instret("rst.instret");
        Reset = 1'b0;
        tick("rst_rel");
        chk("rst_rel.ready", {63'd0, Mem_ready}, 64'd1);

        // ALU writeback
        alu(5'd5, 32'hDEADBEEF, 1'b1, "alu5");
        tick("alu5_after");

        // Loads with data in the accept cycle
        load_now(5'd1, 3'b000, 2'd3, 32'h80AA5511, 32'hFFFFFF80, "lb_off3");
        load_now(5'd2, 3'b100, 2'd3, 32'h80AA5511, 32'h00000080, "lbu_off3");
        load_now(5'd3, 3'b001, 2'd2, 32'h80AA5511, 32'hFFFF80AA, "lh_off2");
        load_now(5'd4, 3'b101, 2'd3, 32'h80AA5511, 32'h000080AA, "lhu_off3");
        load_now(5'd8, 3'b000, 2'd1, 32'h80AA5511, 32'h00000055, "lb_off1");
        load_now(5'd11, 3'b001, 2'd0, 32'h80AA5511, 32'h00005511, "lh_off0");
        load_now(5'd12, 3'b010, 2'd0, 32'h80AA5511, 32'h80AA5511, "lw");
        load_now(5'd13, 3'b011, 2'd0, 32'h80AA5511, 32'h00000000, "f3_011");
        load_now(5'd14, 3'b110, 2'd2, 32'h80AA5511, 32'h00000000, "f3_110");

        // LW with a 3-cycle response; a flushed beat is offered during the wait
        Mem_valid = 1'b1; Mem_is_load = 1'b1; Mem_rd_addr = 5'd7; Mem_rd_wr_en = 1'b1;
        Mem_funct3 = 3'b010; Mem_byte_off = 2'd0; Dmem_rvalid = 1'b0;
        tick("lw7_acc");
        Mem_is_load = 1'b0; Mem_rd_addr = 5'd9; Mem_alu_result = 32'h99; Flush = 1'b1;
        for (int i = 0; i < 2; i++) begin
            chk("wait.busy", {63'd0, Wb_busy}, 64'd1);
            chk("wait.ready", {63'd0, Mem_ready}, 64'd0);
            tick("wait");
        end
        chk("wait3.busy", {63'd0, Wb_busy}, 64'd1);
        chk("wait3.ready", {63'd0, Mem_ready}, 64'd0);
        Dmem_rvalid = 1'b1; Dmem_rdata = 32'h12345678;
        sb.push_back('{a: 5'd7, d: 32'h12345678, we: 1'b1});
        due = 1'b1;
        tick("lw7_done");
        Dmem_rvalid = 1'b0;
        chk("lw7_done.busy", {63'd0, Wb_busy}, 64'd0);
        chk("lw7_done.ready", {63'd0, Mem_ready}, 64'd1);
        Mem_valid = 1'b0; Flush = 1'b0;
        tick("lw7_after");
        chk_instret("lw7.instret");

        // Flushed beat in IDLE, then a stray response with no load pending
        Mem_valid = 1'b1; Flush = 1'b1; Mem_rd_addr = 5'd9; Mem_rd_wr_en = 1'b1;
        Mem_alu_result = 32'h0BADF00D;
        tick("flush");
        Mem_valid = 1'b0; Flush = 1'b0;
        chk_instret("flush.instret");
        Dmem_rvalid = 1'b1; Dmem_rdata = 32'hFFFFFFFF;
        tick("stray_idle");
        Dmem_rvalid = 1'b0;

        // Non-writing instruction and rd==0
        alu(5'd6, 32'h00000055, 1'b0, "no_we");
        alu(5'd0, 32'hCAFEF00D, 1'b1, "rd0");
        chk_instret("rd0.instret");

        // Reset while a load is pending, then a stray response
        Mem_valid = 1'b1; Mem_is_load = 1'b1; Mem_rd_addr = 5'd3; Mem_rd_wr_en = 1'b1;
        Mem_funct3 = 3'b010; Dmem_rvalid = 1'b0;
        tick("lw3_acc");
        Mem_valid = 1'b0; Mem_is_load = 1'b0;
        chk("lw3.busy", {63'd0, Wb_busy}, 64'd1);
        Reset = 1'b1;
        tick("rst_mid");
        chk("rst_mid.ready", {63'd0, Mem_ready}, 64'd0);
        chk("rst_mid.busy", {63'd0, Wb_busy}, 64'd0);
        Reset = 1'b0;
        Dmem_rvalid = 1'b1; Dmem_rdata = 32'hAAAA5555;
        tick("stray_after_rst");
        Dmem_rvalid = 1'b0;
        chk_instret("rst_mid.instret");

        // Four back-to-back ALU beats
        alu(5'd10, 32'h00000001, 1'b1, "b2b0");
        alu(5'd11, 32'h00000002, 1'b1, "b2b1");
        alu(5'd12, 32'h00000003, 1'b1, "b2b2");
        alu(5'd13, 32'h00000004, 1'b1, "b2b3");
        tick("b2b_after");
`ifdef WB_INSTRET_EN
        chk("b2b.instret", Instret, 64'd4);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
